instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder/controller in the single-cycle core.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small FIFO and presents them, PC-tagged, to the decoder over a valid/ready handshake.
- Handles PC redirects from branch/jump resolution by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle around the fetch stage.
// Ports (master = fetch unit, slave = memory/decoder/branch side):
//   imem_req_valid/ready/addr  instruction memory request channel
//   imem_rsp_valid/data        in-order instruction memory responses
//   redirect_valid/pc          branch/jump redirect pulse and target
//   instr_valid/ready          decoder handshake on the FIFO head
//   instruction/instr_pc       FIFO head word and its PC
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid, instr_ready;
  logic [XLEN-1:0] instruction, instr_pc;
  modport master(
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave(
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage issuing in-order imem requests and buffering PC-tagged instructions.
// Ports: clk, reset (async, active-high), bus (instr_fetch_unit_if.master: imem request/response,
//   redirect input, decoder valid/ready with instruction and instr_pc).
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t          state;
  logic [XLEN-1:0] fetch_pc, rsp_pc, tgt;
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [AW-1:0]   rp, wp;
  logic [CW-1:0]   cnt, out, drop_cnt, out_nxt;
  logic            valid, req, acc, push, pop, full, ovf;
  always_comb begin
    tgt = bus.redirect_pc & ~XLEN'(3);
    full = cnt == CW'(DEPTH);
    valid = cnt != '0;
    pop = valid && bus.instr_ready;
    // outstanding requests and buffered entries share one pool of DEPTH credits
    req = state == FETCH && !bus.redirect_valid && int'(out) + int'(cnt) < DEPTH;
    acc = req && bus.imem_req_ready;
    // responses in the redirect cycle or during FLUSH belong to the old path
    ovf = state == FETCH && bus.imem_rsp_valid && !bus.redirect_valid && full && !pop;
    push = state == FETCH && bus.imem_rsp_valid && !bus.redirect_valid && !ovf;
    out_nxt = out + CW'(acc) - CW'(bus.imem_rsp_valid);
    bus.imem_req_valid = req;
    bus.imem_req_addr = fetch_pc;
    bus.instr_valid = valid;
    bus.instruction = valid ? mem_d[rp] : '0;
    bus.instr_pc = valid ? mem_pc[rp] : '0;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wp] <= bus.imem_rsp_data;
      mem_pc[wp] <= rsp_pc;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      out <= '0;
      drop_cnt <= '0;
    end else begin
      out <= out_nxt;
      if (acc) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) begin
        wp <= wp + 1'b1;
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (bus.redirect_valid) begin
        fetch_pc <= tgt;
        rsp_pc <= tgt;
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else begin
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
      case (state)
        IDLE: state <= FETCH;
        FETCH: if (bus.redirect_valid && out_nxt != '0) begin
          state <= FLUSH;
          drop_cnt <= out_nxt;
        end
        FLUSH: if (bus.imem_rsp_valid) begin
          drop_cnt <= drop_cnt - 1'b1;
          if (drop_cnt == CW'(1)) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assert property (@(posedge clk) disable iff (reset) !ovf);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench with an epoch-based model of the fetch stream.
module tb_instr_fetch_unit;
  localparam int D = 2;
  localparam logic [31:0] RST = 32'h0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] mpc;
    int          ep;
    int          due;
  } req_t;
  logic clk, reset;
  instr_fetch_unit_if #(.XLEN(32)) bus();
  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  req_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] next_req;
  int          epoch, cyc, lat_lo, lat_hi, n_chk, n_pass;
  logic        idle;
  logic        c_acc, c_rsp, c_pop, c_redir, c_ival, c_reqv, e_ival, e_reqv;
  logic [31:0] c_addr, c_ipc, c_idata, c_rpc;
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [31:0] f(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  task automatic model_reset();
    pend.delete();
    mq.delete();
    epoch = 0;
    next_req = RST;
    idle = 1;
    bus.imem_rsp_valid = 0;
    bus.redirect_valid = 0;
  endtask
  task automatic tick();
    int   stale;
    req_t r;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1;
      bus.imem_rsp_data = f(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 0;
      bus.imem_rsp_data = $urandom;
    end
    #1;
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale++;
    e_ival = mq.size() != 0;
    e_reqv = !idle && !bus.redirect_valid && stale == 0 && pend.size() + mq.size() < D;
    c_ival = bus.instr_valid;
    c_reqv = bus.imem_req_valid;
    c_addr = bus.imem_req_addr;
    c_ipc = bus.instr_pc;
    c_idata = bus.instruction;
    c_acc = bus.imem_req_valid && bus.imem_req_ready;
    c_rsp = bus.imem_rsp_valid;
    c_pop = bus.instr_valid && bus.instr_ready;
    c_redir = bus.redirect_valid;
    c_rpc = bus.redirect_pc;
    n_chk++;
    if (c_ival !== e_ival) $display("FAIL instr_valid cyc=%0d got %b exp %b", cyc, c_ival, e_ival);
    else n_pass++;
    if (e_ival) begin
      n_chk++;
      if (c_ipc !== mq[0]) $display("FAIL instr_pc cyc=%0d got %h exp %h", cyc, c_ipc, mq[0]);
      else n_pass++;
      n_chk++;
      if (c_idata !== f(mq[0])) $display("FAIL instruction cyc=%0d got %h exp %h", cyc, c_idata, f(mq[0]));
      else n_pass++;
    end
    n_chk++;
    if (c_reqv !== e_reqv) $display("FAIL imem_req_valid cyc=%0d got %b exp %b", cyc, c_reqv, e_reqv);
    else n_pass++;
    n_chk++;
    if (c_addr !== next_req) $display("FAIL imem_req_addr cyc=%0d got %h exp %h", cyc, c_addr, next_req);
    else n_pass++;
    @(posedge clk);
    if (c_redir) begin
      epoch++;
      mq.delete();
      next_req = c_rpc & ~32'h3;
    end else if (c_pop && mq.size() > 0) void'(mq.pop_front());
    if (c_acc) begin
      pend.push_back('{addr: c_addr, mpc: next_req, ep: epoch, due: cyc + $urandom_range(lat_hi, lat_lo)});
      next_req += 4;
    end
    if (c_rsp) begin
      r = pend.pop_front();
      if (r.ep == epoch) mq.push_back(r.mpc);
    end
    idle = 0;
    cyc++;
    @(negedge clk);
    bus.redirect_valid = 0;
  endtask
  task automatic drain();
    int k;
    bus.imem_req_ready = 0;
    bus.instr_ready = 1;
    for (k = 0; k < 60 && (pend.size() != 0 || mq.size() != 0); k++) tick();
    n_chk++;
    if (pend.size() != 0 || mq.size() != 0) $display("FAIL drain_timeout pend=%0d fifo=%0d exp 0", pend.size(), mq.size());
    else n_pass++;
  endtask
  task automatic test_reset();
    reset = 1;
    bus.imem_req_ready = 1;
    bus.instr_ready = 1;
    bus.redirect_pc = 0;
    lat_lo = 1;
    lat_hi = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc, bus.imem_req_addr} !== {2'b00, 64'h0, RST})
      $display("FAIL reset_outputs got %b %b %h %h %h", bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc, bus.imem_req_addr);
    else n_pass++;
    reset = 0;
    tick();
    n_chk++;
    if (c_reqv !== 1'b0) $display("FAIL idle_no_request got %b exp 0", c_reqv);
    else n_pass++;
    tick();
    n_chk++;
    if (c_reqv !== 1'b1 || c_addr !== RST) $display("FAIL first_request got %b %h exp 1 %h", c_reqv, c_addr, RST);
    else n_pass++;
  endtask
  task automatic test_stream();
    int pops = 0;
    logic [31:0] last = RST - 4;
    bus.imem_req_ready = 1;
    bus.instr_ready = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c_pop) begin
        n_chk++;
        if (c_ipc !== last + 4) $display("FAIL stream_seq got %h exp %h", c_ipc, last + 4);
        else n_pass++;
        last = c_ipc;
        pops++;
      end
    end
    n_chk++;
    if (pops < 20) $display("FAIL stream_rate got %0d pops exp >=20", pops);
    else n_pass++;
  endtask
  task automatic test_backpressure();
    int n = 0;
    drain();
    bus.imem_req_ready = 1;
    bus.instr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n += int'(c_acc);
    end
    n_chk++;
    if (n != D) $display("FAIL bp_requests got %0d exp %0d", n, D);
    else n_pass++;
    n_chk++;
    if (c_reqv !== 1'b0 || c_ival !== 1'b1) $display("FAIL bp_full got req=%b ival=%b exp 0 1", c_reqv, c_ival);
    else n_pass++;
    bus.instr_ready = 1;
    repeat (20) tick();
  endtask
  task automatic test_redirect_flush();
    int k, drops = 0;
    lat_lo = 1;
    lat_hi = 6;
    bus.imem_req_ready = 1;
    for (k = 0; k < 200 && !(pend.size() == 1 && mq.size() == 1 && pend[0].due > cyc); k++) begin
      bus.instr_ready = $urandom_range(1, 0);
      tick();
    end
    n_chk++;
    if (k == 200) $display("FAIL flush_setup_timeout got pend=%0d fifo=%0d exp 1 1", pend.size(), mq.size());
    else n_pass++;
    bus.instr_ready = 0;
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h100;
    tick();
    tick();
    n_chk++;
    if (c_ival !== 1'b0) $display("FAIL flush_fifo_cleared got %b exp 0", c_ival);
    else n_pass++;
    drops = int'(c_rsp);
    for (k = 0; k < 20 && !c_acc; k++) begin
      tick();
      if (!c_acc) drops += int'(c_rsp);
    end
    n_chk++;
    if (!c_acc || c_addr !== 32'h100) $display("FAIL flush_next_addr got acc=%b %h exp 1 00000100", c_acc, c_addr);
    else n_pass++;
    n_chk++;
    if (drops != 1) $display("FAIL flush_drops got %0d exp 1", drops);
    else n_pass++;
    bus.instr_ready = 1;
    for (k = 0; k < 20 && !c_pop; k++) tick();
    n_chk++;
    if (!c_pop || c_ipc !== 32'h100) $display("FAIL flush_next_pc got pop=%b %h exp 1 00000100", c_pop, c_ipc);
    else n_pass++;
  endtask
  task automatic test_redirect_pop_rsp();
    int k;
    logic [31:0] hp;
    logic found = 0;
    lat_lo = 2;
    lat_hi = 2;
    bus.imem_req_ready = 1;
    bus.instr_ready = 1;
    for (k = 0; k < 80 && !found; k++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && mq.size() > 0) begin
        hp = mq[0];
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'h203;
        tick();
        found = 1;
        n_chk++;
        if (c_pop !== 1'b1 || c_rsp !== 1'b1 || c_ipc !== hp)
          $display("FAIL rpr_same_cycle got pop=%b rsp=%b pc=%h exp 1 1 %h", c_pop, c_rsp, c_ipc, hp);
        else n_pass++;
      end else tick();
    end
    n_chk++;
    if (!found) $display("FAIL rpr_setup_timeout got 0 exp 1");
    else n_pass++;
    tick();
    for (k = 0; k < 20 && !c_acc; k++) tick();
    n_chk++;
    if (!c_acc || c_addr !== 32'h200) $display("FAIL rpr_next_addr got acc=%b %h exp 1 00000200", c_acc, c_addr);
    else n_pass++;
    for (k = 0; k < 20 && !c_pop; k++) tick();
    n_chk++;
    if (!c_pop || c_ipc !== 32'h200) $display("FAIL rpr_next_pc got pop=%b %h exp 1 00000200", c_pop, c_ipc);
    else n_pass++;
  endtask
  task automatic test_ready_toggle();
    logic t = 1, pv = 0, pacc = 0, seen = 0;
    logic [31:0] paddr = 0, last = 0;
    lat_lo = 3;
    lat_hi = 3;
    bus.instr_ready = 1;
    for (int i = 0; i < 40; i++) begin
      bus.imem_req_ready = t;
      t = !t;
      tick();
      if (pv && !pacc) begin
        n_chk++;
        if (c_reqv !== 1'b1 || c_addr !== paddr) $display("FAIL toggle_hold got %b %h exp 1 %h", c_reqv, c_addr, paddr);
        else n_pass++;
      end
      if (c_pop) begin
        if (seen) begin
          n_chk++;
          if (c_ipc !== last + 4) $display("FAIL toggle_seq got %h exp %h", c_ipc, last + 4);
          else n_pass++;
        end
        seen = 1;
        last = c_ipc;
      end
      pv = c_reqv;
      pacc = c_acc;
      paddr = c_addr;
    end
  endtask
  task automatic test_random();
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      bus.imem_req_ready = ($urandom % 4) != 0;
      bus.instr_ready = ($urandom % 3) != 0;
      if ($urandom % 25 == 0) begin
        bus.redirect_valid = 1;
        bus.redirect_pc = $urandom & 32'h0000_0fff;
      end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    int k;
    lat_lo = 1;
    lat_hi = 3;
    bus.imem_req_ready = 1;
    bus.instr_ready = 1;
    repeat (15) tick();
    #2;
    reset = 1;
    model_reset();
    #1;
    n_chk++;
    if ({bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc, bus.imem_req_addr} !== {2'b00, 64'h0, RST})
      $display("FAIL midreset_outputs got %b %b %h %h %h", bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc, bus.imem_req_addr);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    tick();
    n_chk++;
    if (c_reqv !== 1'b0) $display("FAIL midreset_idle got %b exp 0", c_reqv);
    else n_pass++;
    tick();
    n_chk++;
    if (c_reqv !== 1'b1 || c_addr !== RST) $display("FAIL midreset_restart got %b %h exp 1 %h", c_reqv, c_addr, RST);
    else n_pass++;
    for (k = 0; k < 20 && !c_pop; k++) tick();
    n_chk++;
    if (!c_pop || c_ipc !== RST) $display("FAIL midreset_first_pc got pop=%b %h exp 1 %h", c_pop, c_ipc, RST);
    else n_pass++;
    repeat (10) tick();
  endtask
  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_pop_rsp();
    test_ready_toggle();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
